// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg
//   Shared definitions for the MIPS32 front end: data/PC widths, the all-zero
//   word used for cleared pipeline registers, the NOP encoding, and the
//   fetch FSM state type.
package mips_defs_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0000;

    // START: post-reset idle cycle, ROM disabled
    // RUN  : normal fetch, ROM enabled
    typedef enum logic {
        START = 1'b0,
        RUN   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// pc_reg
//   Program counter, the START/RUN fetch FSM and the next-PC mux.
//   Optional feature: FETCH_ALIGN_CHK_EN adds misaligned-branch rejection.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   stall, flush       - downstream hold / kill requests
//   branch_flag        - redirect request, target in branch_target
//   pc                 - current PC (byte address)
//   run                - FSM is in RUN (drives the ROM enable)
//   branch_reject      - (FETCH_ALIGN_CHK_EN only) branch target is not
//                        word aligned, so the redirect must be refused
module pc_reg
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_flag,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc,
`ifdef FETCH_ALIGN_CHK_EN
    output logic            branch_reject,
`endif
    output logic            run
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            reject;

`ifdef FETCH_ALIGN_CHK_EN
    assign reject        = (branch_target[1:0] != 2'b00);
    assign branch_reject = reject;
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Priority in RUN: flush > branch > stall > sequential.
    // A flush still advances the PC; only the captured instruction is killed.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (flush) begin
                    pc_d = pc_q + 32'd4;
                end else if (branch_flag) begin
                    if (!reject) pc_d = branch_target;
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: state_d = START;
        endcase
    end

    assign pc  = pc_q;
    assign run = (state_q == RUN);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   MIPS32 instruction-fetch stage. Drives a word address to a combinational
//   instruction ROM and captures PC + instruction into the IF/ID register.
//   Optional feature: FETCH_ALIGN_CHK_EN (adds fetch_misalign output).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   rom_ce, rom_addr   - ROM enable and word address (pc[ADDR_W+1:2])
//   rom_data           - instruction returned by the ROM in the same cycle
//   stall, flush       - downstream hold / bubble-insert requests
//   branch_flag/target - PC redirect
//   id_pc, id_inst     - IF/ID register contents
//   id_valid           - IF/ID holds a real instruction
//   fetch_misalign     - (FETCH_ALIGN_CHK_EN only) one-cycle pulse when a
//                        misaligned branch target was rejected
module inst_fetch
    import mips_defs_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_flag,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
`ifdef FETCH_ALIGN_CHK_EN
    output logic              fetch_misalign,
`endif
    output logic              id_valid
);

    logic [PC_W-1:0]   pc;
    logic              run;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
    logic              branch_reject;
    logic              misalign_q, misalign_d;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (pc),
`ifdef FETCH_ALIGN_CHK_EN
        .branch_reject (branch_reject),
`endif
        .run           (run)
    );

    // Word address; upper PC bits are dropped so the fetch wraps in the ROM.
    assign rom_addr = pc[ADDR_W+1:2];
    assign rom_ce   = run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= ZERO_WORD;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Branch kills the instruction fetched alongside it (no delay slot),
    // but leaves id_pc alone since id_valid=0 already marks it as junk.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
`ifdef FETCH_ALIGN_CHK_EN
        misalign_d = 1'b0;
`endif
        if (run) begin
            if (flush) begin
                id_pc_d    = ZERO_WORD;
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end else if (branch_flag) begin
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                misalign_d = branch_reject;
`endif
            end else if (!stall) begin
                id_pc_d    = pc;
                id_inst_d  = rom_data;
                id_valid_d = 1'b1;
            end
        end
    end

    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    logic [31:0] rom [32];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the spec says the stage should be holding.
    logic        m_run;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic        m_mis;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    inst_fetch #(
        .ADDR_W   (5),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .flush         (flush),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
`ifdef FETCH_ALIGN_CHK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .id_valid      (id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
        m_mis      = 1'b0;
    endtask

    task automatic check_all();
        chk("rom_ce",   {31'h0, rom_ce},   {31'h0, m_run});
        chk("rom_addr", {27'h0, rom_addr}, (m_pc / 4) % 32);
        chk("id_pc",    id_pc,             m_id_pc);
        chk("id_inst",  id_inst,           m_id_inst);
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_id_valid});
`ifdef FETCH_ALIGN_CHK_EN
        chk("fetch_misalign", {31'h0, fetch_misalign}, {31'h0, m_mis});
`endif
    endtask

    // Called at a falling edge: drive, check the cycle, advance one edge.
    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
        logic        bad_align;
        logic [31:0] fetched;
        stall         = s;
        flush         = f;
        branch_flag   = b;
        branch_target = t;
        #1;
        check_all();
        fetched = rom[(m_pc / 4) % 32];
`ifdef FETCH_ALIGN_CHK_EN
        bad_align = (t % 4) != 0;
`else
        bad_align = 1'b0;
`endif
        @(posedge clk);
        m_mis = 1'b0;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (f) begin
            m_pc       = m_pc + 4;
            m_id_pc    = 32'h0;
            m_id_inst  = 32'h0;
            m_id_valid = 1'b0;
        end else if (b) begin
            if (bad_align) m_mis = 1'b1;
            else           m_pc  = t;
            m_id_inst  = 32'h0;
            m_id_valid = 1'b0;
        end else if (!s) begin
            m_id_pc    = m_pc;
            m_id_inst  = fetched;
            m_id_valid = 1'b1;
            m_pc       = m_pc + 4;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0] = 32'h3412013c;
        rom[1] = 32'hcdab2134;
        model_reset();

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cycle 0 (START) then first two fetches.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("first_inst",  id_inst, 32'h3412013c);
        chk("first_pc",    id_pc,   32'h0);
        chk("first_valid", {31'h0, id_valid}, 32'h1);
        step(0, 0, 0, 0);
        chk("second_inst", id_inst, 32'hcdab2134);
        chk("second_pc",   id_pc,   32'h4);

        // Stall three cycles at pc=8, then release.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("stall_addr", {27'h0, rom_addr}, 32'd2);
        chk("stall_pc",   id_pc, 32'h4);
        step(0, 0, 0, 0);
        chk("after_stall_pc", id_pc, 32'h8);

        // Branch beats stall.
        step(1, 0, 1, 32'h14);
        chk("br_addr",  {27'h0, rom_addr}, 32'd5);
        chk("br_valid", {31'h0, id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("br_tgt_pc",   id_pc,   32'h14);
        chk("br_tgt_inst", id_inst, rom[5]);

        // Flush at pc=0x10.
        step(0, 0, 1, 32'h10);
        step(1, 1, 0, 0);
        chk("flush_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_inst",  id_inst, 32'h0);
        chk("flush_addr",  {27'h0, rom_addr}, 32'd5);

        // ROM-address wrap past word 31.
        step(0, 0, 1, 32'h7C);
        step(0, 0, 0, 0);
        chk("wrap_addr", {27'h0, rom_addr}, 32'd0);
        chk("wrap_idpc", id_pc, 32'h7C);
        step(0, 0, 0, 0);
        chk("wrap_pc",   id_pc,   32'h80);
        chk("wrap_inst", id_inst, rom[0]);

`ifdef FETCH_ALIGN_CHK_EN
        step(0, 0, 1, 32'h13);
        chk("mis_pulse", {31'h0, fetch_misalign}, 32'h1);
        step(0, 0, 0, 0);
        chk("mis_clear", {31'h0, fetch_misalign}, 32'h0);
`endif

        // Asynchronous reset in the middle of a RUN cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ce",    {31'h0, rom_ce},   32'h0);
        chk("arst_valid", {31'h0, id_valid}, 32'h0);
        chk("arst_pc",    id_pc,             32'h0);
        chk("arst_inst",  id_inst,           32'h0);
        chk("arst_addr",  {27'h0, rom_addr}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rerun_inst", id_inst, 32'h3412013c);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic        s, f, b;
            logic [31:0] t;
            s = ($urandom % 4) == 0;
            f = ($urandom % 10) == 0;
            b = ($urandom % 8) == 0;
            if (($urandom % 6) == 0) t = $urandom;
            else                     t = $urandom & 32'h7C;
            step(s, f, b, t);
        end
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
